mt_reg_file_v2: RTL and testbench



---
 rtl/mt_reg_file_v2.sv | 124 ++++++++++++
 tb/tb_mt_reg_file_v2.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mt_reg_file_v2.sv
// Multithreaded 2-read / 2-write register file with a power-on zeroing sweep
// and a per-thread context clear sequenced by a small FSM.
module mt_reg_file_v2 #(
    parameter int unsigned NUM_THREADS  = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BITS_THREADS = $clog2(NUM_THREADS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BITS_THREADS-1:0] tid_read,
    input  logic [4:0]              a1,
    input  logic [4:0]              a2,
    output logic [DATA_WIDTH-1:0]   rd1,
    output logic [DATA_WIDTH-1:0]   rd2,
    input  logic                    we0,
    input  logic [BITS_THREADS-1:0] tid_w0,
    input  logic [4:0]              a3_0,
    input  logic [DATA_WIDTH-1:0]   wd0,
    input  logic                    we1,
    input  logic [BITS_THREADS-1:0] tid_w1,
    input  logic [4:0]              a3_1,
    input  logic [DATA_WIDTH-1:0]   wd1,
    input  logic                    clr_req,
    input  logic [BITS_THREADS-1:0] clr_tid,
    output logic                    clr_ack,
    output logic                    ready
);
    localparam int unsigned DEPTH = 32 * NUM_THREADS;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        cnt;
    logic [BITS_THREADS-1:0] clr_tid_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    wr0_ok_c;
    logic                    wr1_ok_c;

    function automatic logic [IDX_W-1:0] idx(input logic [BITS_THREADS-1:0] t,
                                             input logic [4:0] a);
        return IDX_W'({t, a});
    endfunction

    // Read mux: x0, sweep and the thread under clear read as zero; port 1 bypass wins.
    function automatic logic [DATA_WIDTH-1:0] read_sel(input logic [BITS_THREADS-1:0] t,
                                                       input logic [4:0] a);
        logic [DATA_WIDTH-1:0] d;
        d = mem[idx(t, a)];
        if (state == INIT || a == 5'd0 || (state == CLEAR && t == clr_tid_q))
            d = '0;
        else if (we1 && tid_w1 == t && a3_1 == a)
            d = wd1;
        else if (we0 && tid_w0 == t && a3_0 == a)
            d = wd0;
        return d;
    endfunction

    always_comb begin
        rd1 = read_sel(tid_read, a1);
        rd2 = read_sel(tid_read, a2);
    end

    always_comb begin
        wr0_ok_c = we0 && a3_0 != 5'd0 && state != INIT
                   && !(state == CLEAR && tid_w0 == clr_tid_q);
        wr1_ok_c = we1 && a3_1 != 5'd0 && state != INIT
                   && !(state == CLEAR && tid_w1 == clr_tid_q);
    end

    // Storage has no reset; the sweep defines contents after power-on.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[cnt] <= '0;
        end else begin
            if (state == CLEAR)
                mem[idx(clr_tid_q, cnt[4:0])] <= '0;
            if (wr0_ok_c)
                mem[idx(tid_w0, a3_0)] <= wd0;
            if (wr1_ok_c)
                mem[idx(tid_w1, a3_1)] <= wd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            cnt       <= '0;
            clr_tid_q <= '0;
            ready     <= 1'b0;
            clr_ack   <= 1'b0;
        end else begin
            clr_ack <= 1'b0;
            case (state)
                INIT: begin
                    if (cnt == IDX_W'(DEPTH - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        clr_tid_q <= clr_tid;
                        cnt       <= IDX_W'(1);
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (cnt[4:0] == 5'd31) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        clr_ack <= 1'b1;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_mt_reg_file_v2.sv
// Directed table-driven bench for mt_reg_file_v2 (NUM_THREADS=8, DATA_WIDTH=32).
module tb_mt_reg_file_v2;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  tid_read;
    logic [4:0]  a1, a2;
    logic [31:0] rd1, rd2;
    logic        we0, we1;
    logic [2:0]  tid_w0, tid_w1;
    logic [4:0]  a3_0, a3_1;
    logic [31:0] wd0, wd1;
    logic        clr_req;
    logic [2:0]  clr_tid;
    logic        clr_ack;
    logic        ready;

    int errors = 0;
    int checks = 0;

    mt_reg_file_v2 dut (
        .clk(clk), .rst_n(rst_n), .tid_read(tid_read), .a1(a1), .a2(a2),
        .rd1(rd1), .rd2(rd2), .we0(we0), .tid_w0(tid_w0), .a3_0(a3_0), .wd0(wd0),
        .we1(we1), .tid_w1(tid_w1), .a3_1(a3_1), .wd1(wd1),
        .clr_req(clr_req), .clr_tid(clr_tid), .clr_ack(clr_ack), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we0;
        logic [2:0]  tid_w0;
        logic [4:0]  a3_0;
        logic [31:0] wd0;
        logic        we1;
        logic [2:0]  tid_w1;
        logic [4:0]  a3_1;
        logic [31:0] wd1;
        logic [2:0]  tid_read;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vec [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; tid_w0 = 3'd0; a3_0 = 5'd0; wd0 = 32'd0;
        we1 = 1'b0; tid_w1 = 3'd0; a3_1 = 5'd0; wd1 = 32'd0;
        clr_req = 1'b0; clr_tid = 3'd0;
        tid_read = 3'd0; a1 = 5'd0; a2 = 5'd0;
    endtask

    task automatic read_check(input string name, input logic [2:0] t, input logic [4:0] a,
                              input logic [31:0] exp);
        tid_read = t; a1 = a; a2 = a;
        #1;
        check({name, "_rd1"}, rd1, exp);
        check({name, "_rd2"}, rd2, exp);
    endtask

    // Counts edges from release; ready must be low after 255 and high after 256.
    task automatic sweep_check(input string name);
        for (int i = 1; i <= 256; i++) begin
            step();
            if (i == 1 || i == 255) check({name, "_ready_low"}, 32'(ready), 32'd0);
            if (i == 256) check({name, "_ready_high"}, 32'(ready), 32'd1);
            if (clr_ack) check({name, "_no_ack"}, 32'(clr_ack), 32'd0);
        end
    endtask

    // clr_req driven in the current cycle; ack must appear only after the 32nd edge.
    task automatic clear_seq(input logic [2:0] t, input logic [2:0] next_t, input logic chain);
        int acks;
        acks = 0;
        clr_req = 1'b1; clr_tid = t;
        for (int e = 1; e <= 32; e++) begin
            step();
            clr_req = 1'b0;
            if (clr_ack) acks++;
            if (e == 31) check("clr_ack_early", 32'(clr_ack), 32'd0);
            if (e == 32) check("clr_ack_pulse", 32'(clr_ack), 32'd1);
            if (e == 10) check("ready_in_clear", 32'(ready), 32'd1);
        end
        if (chain) begin
            clr_req = 1'b1; clr_tid = next_t;
        end
        step();
        clr_req = 1'b0;
        check("clr_ack_one_cycle", 32'(clr_ack), 32'd0);
        check("clr_ack_count", 32'(acks), 32'd1);
    endtask

    initial begin
        vec[0] = '{1'b1, 3'd3, 5'd5, 32'hAAAA_0001, 1'b1, 3'd3, 5'd5, 32'h5555_0002,
                   3'd3, 5'd5, 5'd5, 32'h5555_0002, 32'h5555_0002};
        vec[1] = '{1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 3'd0, 5'd0, 32'h0,
                   3'd3, 5'd5, 5'd6, 32'h5555_0002, 32'h0};
        vec[2] = '{1'b1, 3'd2, 5'd0, 32'hDEAD_BEEF, 1'b0, 3'd0, 5'd0, 32'h0,
                   3'd2, 5'd0, 5'd0, 32'h0, 32'h0};
        vec[3] = '{1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 3'd0, 5'd0, 32'h0,
                   3'd2, 5'd0, 5'd0, 32'h0, 32'h0};
        vec[4] = '{1'b1, 3'd1, 5'd3, 32'h1111_0003, 1'b0, 3'd0, 5'd0, 32'h0,
                   3'd1, 5'd3, 5'd4, 32'h1111_0003, 32'h0};
        vec[5] = '{1'b1, 3'd6, 5'd4, 32'h0000_0099, 1'b1, 3'd1, 5'd4, 32'h2222_0004,
                   3'd1, 5'd3, 5'd4, 32'h1111_0003, 32'h2222_0004};
        vec[6] = '{1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 3'd0, 5'd0, 32'h0,
                   3'd6, 5'd4, 5'd3, 32'h0000_0099, 32'h0};
        vec[7] = '{1'b1, 3'd6, 5'd9, 32'hCAFE_0009, 1'b0, 3'd0, 5'd0, 32'h0,
                   3'd6, 5'd9, 5'd4, 32'hCAFE_0009, 32'h0000_0099};
        vec[8] = '{1'b1, 3'd1, 5'd4, 32'h0000_0077, 1'b1, 3'd0, 5'd4, 32'h0BAD_0000,
                   3'd1, 5'd4, 5'd3, 32'h0000_0077, 32'h1111_0003};

        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_clr_ack", 32'(clr_ack), 32'd0);
        tid_read = 3'd3; a1 = 5'd5; a2 = 5'd7;
        #1;
        check("reset_rd1", rd1, 32'd0);
        check("reset_rd2", rd2, 32'd0);
        step(); step();
        rst_n = 1'b1;
        sweep_check("por");

        for (int t = 0; t < 8; t++)
            for (int a = 0; a < 32; a++)
                read_check("por_zero", 3'(t), 5'(a), 32'd0);

        for (int v = 0; v < 9; v++) begin
            we0 = vec[v].we0; tid_w0 = vec[v].tid_w0; a3_0 = vec[v].a3_0; wd0 = vec[v].wd0;
            we1 = vec[v].we1; tid_w1 = vec[v].tid_w1; a3_1 = vec[v].a3_1; wd1 = vec[v].wd1;
            tid_read = vec[v].tid_read; a1 = vec[v].a1; a2 = vec[v].a2;
            #1;
            check($sformatf("vec%0d_rd1", v), rd1, vec[v].exp1);
            check($sformatf("vec%0d_rd2", v), rd2, vec[v].exp2);
            step();
        end
        idle_inputs();
        read_check("after_vec_t1x4", 3'd1, 5'd4, 32'h0000_0077);
        read_check("after_vec_t0x4", 3'd0, 5'd4, 32'h0BAD_0000);

        for (int r = 1; r < 32; r++) begin
            we0 = 1'b1; tid_w0 = 3'd4; a3_0 = 5'(r); wd0 = 32'h4000_0000 | 32'(r);
            we1 = 1'b1; tid_w1 = 3'd5; a3_1 = 5'(r); wd1 = 32'h5000_0000 | 32'(r);
            step();
        end
        idle_inputs();
        read_check("fill_t4x17", 3'd4, 5'd17, 32'h4000_0011);

        // Clear tid 4 with a dropped and a committed write injected mid-sequence.
        fork
            clear_seq(3'd4, 3'd0, 1'b0);
            begin
                repeat (10) @(posedge clk);
                #2;
                we0 = 1'b1; tid_w0 = 3'd4; a3_0 = 5'd7; wd0 = 32'h0000_0BAD;
                we1 = 1'b1; tid_w1 = 3'd1; a3_1 = 5'd7; wd1 = 32'h0000_1234;
                tid_read = 3'd4; a1 = 5'd7; a2 = 5'd20;
                #1;
                check("clear_rd_t4_nobypass", rd1, 32'd0);
                check("clear_rd_t4_old", rd2, 32'd0);
                @(posedge clk);
                #2;
                we0 = 1'b0; we1 = 1'b0;
            end
        join
        for (int a = 0; a < 32; a++) read_check("t4_cleared", 3'd4, 5'(a), 32'd0);
        for (int a = 1; a < 32; a++)
            read_check("t5_kept", 3'd5, 5'(a), 32'h5000_0000 | 32'(a));
        read_check("t1x7_written", 3'd1, 5'd7, 32'h0000_1234);

        // Back-to-back: request for tid 1 accepted while the tid 6 ack is high.
        clear_seq(3'd6, 3'd1, 1'b1);
        read_check("t6x4_cleared", 3'd6, 5'd4, 32'd0);
        begin
            int acks;
            acks = 0;
            for (int e = 2; e <= 33; e++) begin
                step();
                if (clr_ack) acks++;
                if (e == 31) check("chain_ack_early", 32'(clr_ack), 32'd0);
            end
            check("chain_ack_seen", 32'(acks), 32'd1);
        end
        read_check("t1x7_cleared", 3'd1, 5'd7, 32'd0);
        read_check("t5x9_kept", 3'd5, 5'd9, 32'h5000_0009);

        // Reset 10 cycles into a clear of tid 5: no ack, full sweep restarts.
        clr_req = 1'b1; clr_tid = 3'd5;
        step();
        clr_req = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_clr_ack", 32'(clr_ack), 32'd0);
        read_check("abort_rd", 3'd5, 5'd30, 32'd0);
        step(); step();
        rst_n = 1'b1;
        sweep_check("restart");
        read_check("restart_t5x30", 3'd5, 5'd30, 32'd0);
        read_check("restart_t1x4", 3'd1, 5'd4, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
